id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register, the successor to the plain always-latching ID/EX stage.
- Adds valid/ready handshaking, so EX can back-pressure ID.
- Adds an optional 2-entry skid buffer, which keeps in_ready a registered signal.
- Adds synchronous flush for branch/hazard squash and a saturating EX-idle (bubble) counter.
- Sits between the decode/register-file stage and the ALU/forwarding stage.

---
 rtl/id_ex_pipe_reg.sv | 147 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register with valid/ready handshaking, an optional
//   2-entry skid buffer, synchronous flush and a saturating EX-idle counter.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             synchronous squash of every held entry
//   in_valid/in_ready upstream (decode) handshake
//   in_*              decoded control, register data, immediate, specifiers
//   out_valid/out_ready downstream (execute) handshake
//   out_*             head entry; out_ctrl reads as zero while out_valid=0
//   bubble_cnt        saturating count of edges where EX was ready but idle
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 9,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_rs_data,
  input  logic [DATA_W-1:0]     in_rt_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_rs_data,
  output logic [DATA_W-1:0]     out_rt_data,
  output logic [DATA_W-1:0]     out_imm,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [CNT_W-1:0]      bubble_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  // Encoding chosen so bit0 is the main valid bit and bit1 the skid valid
  // bit; in_ready can then come straight off a flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_t;

  state_t           r_state;
  entry_t           r_main;
  entry_t           r_skid;
  logic [CNT_W-1:0] r_bubble;

  entry_t w_in_entry;
  logic   w_out_valid;
  logic   w_in_ready;
  logic   w_in_fire;
  logic   w_out_fire;

  assign w_in_entry = '{ctrl: in_ctrl, rs_data: in_rs_data, rt_data: in_rt_data,
                        imm: in_imm, rs: in_rs, rt: in_rt, rd: in_rd};

  assign w_out_valid = r_state[0];
  // Skid variant: registered ready. Single-register variant: ready passes
  // through combinationally so a draining entry can be replaced in place.
  assign w_in_ready  = (SKID != 0) ? ~r_state[1] : (~r_state[0] | out_ready);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only validity is squashed.
      r_state <= ST_EMPTY;
    end else if (SKID != 0) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_main  <= w_in_entry;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_in_entry;
          end else if (w_in_fire) begin
            r_skid  <= w_in_entry;
            r_state <= ST_TWO;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end else begin
      if (w_in_fire) begin
        r_main  <= w_in_entry;
        r_state <= ST_ONE;
      end else if (w_out_fire) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble <= '0;
    end else if (!w_out_valid && out_ready && (r_bubble != '1)) begin
      r_bubble <= r_bubble + CNT_W'(1);
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  // Bubbles carry no control so no write/branch side effects leak into EX.
  assign out_ctrl    = w_out_valid ? r_main.ctrl : '0;
  assign out_rs_data = r_main.rs_data;
  assign out_rt_data = r_main.rt_data;
  assign out_imm     = r_main.imm;
  assign out_rs      = r_main.rs;
  assign out_rt      = r_main.rt;
  assign out_rd      = r_main.rd;
  assign bubble_cnt  = r_bubble;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic [8:0]  in_ctrl;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;

  // main instance: SKID=1, CNT_W=16
  logic        in_valid, out_ready, in_ready, out_valid;
  logic [8:0]  out_ctrl;
  logic [31:0] out_rs_data, out_rt_data, out_imm;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [15:0] bubble_cnt;

  // single-register instance: SKID=0
  logic        in_valid0, out_ready0, in_ready0, out_valid0;
  logic [8:0]  out_ctrl0;
  logic [31:0] out_rs_data0, out_rt_data0, out_imm0;
  logic [4:0]  out_rs0, out_rt0, out_rd0;
  logic [15:0] bubble_cnt0;

  // saturation instance: CNT_W=4
  logic        in_valid_s, out_ready_s, in_ready_s, out_valid_s;
  logic [8:0]  out_ctrl_s;
  logic [31:0] out_rs_data_s, out_rt_data_s, out_imm_s;
  logic [4:0]  out_rs_s, out_rt_s, out_rd_s;
  logic [3:0]  bubble_cnt_s;

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(9), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .bubble_cnt(bubble_cnt));

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(9), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0),
    .out_rs_data(out_rs_data0), .out_rt_data(out_rt_data0), .out_imm(out_imm0),
    .out_rs(out_rs0), .out_rt(out_rt0), .out_rd(out_rd0), .bubble_cnt(bubble_cnt0));

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(9), .SKID(1), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_ctrl(in_ctrl),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_ctrl(out_ctrl_s),
    .out_rs_data(out_rs_data_s), .out_rt_data(out_rt_data_s), .out_imm(out_imm_s),
    .out_rs(out_rs_s), .out_rt(out_rt_s), .out_rd(out_rd_s), .bubble_cnt(bubble_cnt_s));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] c, input logic [31:0] d, input logic [4:0] r);
    in_ctrl    = c;
    in_rs_data = d;
    in_rt_data = d + 32'h100;
    in_imm     = 32'hFFFF_FF00 | d;
    in_rs      = r;
    in_rt      = r + 5'd1;
    in_rd      = r + 5'd2;
  endtask

  logic [31:0] stream_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [8:0]  stream_c [4] = '{9'h0A3, 9'h041, 9'h118, 9'h1FF};

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_valid_s = 1'b0; out_ready_s = 1'b1;
    drive(9'h0, 32'h0, 5'd0);
    tick(); tick();

    // reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_rs_data", out_rs_data, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_bubble_sat", bubble_cnt_s, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // saturation on the CNT_W=4 instance
    for (int i = 0; i < 10; i++) tick();
    check("sat_count10", bubble_cnt_s, 10);
    for (int i = 0; i < 20; i++) tick();
    check("sat_hold15", bubble_cnt_s, 15);
    check("sat_main_idle", bubble_cnt, 0);

    reset = 1'b1; tick(); reset = 1'b0;

    // streaming, one-cycle latency
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(stream_c[i], stream_d[i], 5'(i + 1));
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_rs_data", out_rs_data, stream_d[i]);
      check("stream_ctrl", out_ctrl, stream_c[i]);
    end
    check("stream_rt_data", out_rt_data, 32'h144);
    check("stream_imm", out_imm, 32'hFFFF_FF44);
    check("stream_rs", out_rs, 4);
    check("stream_rt", out_rt, 5);
    check("stream_rd", out_rd, 6);
    check("stream_bubble", bubble_cnt, 1);

    // bubble control: drained 9'h1FF entry leaves zero control, data held
    in_valid = 1'b0;
    tick();
    check("bub_valid", out_valid, 0);
    check("bub_ctrl", out_ctrl, 0);
    check("bub_rs_hold", out_rs_data, 32'h44);
    check("bub_cnt_nochg", bubble_cnt, 1);
    tick();
    check("bub_cnt_inc", bubble_cnt, 2);

    // back-pressure through the skid buffer
    out_ready = 1'b0; in_valid = 1'b1;
    drive(9'h022, 32'hA, 5'd1);
    tick();
    check("bp_ready_one", in_ready, 1);
    check("bp_head_A", out_rs_data, 32'hA);
    drive(9'h022, 32'hB, 5'd2);
    tick();
    check("bp_ready_two", in_ready, 0);
    check("bp_hold_A", out_rs_data, 32'hA);
    check("bp_valid_A", out_valid, 1);
    drive(9'h022, 32'hC, 5'd3);
    out_ready = 1'b1;
    tick();
    check("bp_head_B", out_rs_data, 32'hB);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_head_C", out_rs_data, 32'hC);
    check("bp_valid_C", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 0);

    // flush with two entries held and an input offered
    out_ready = 1'b0; in_valid = 1'b1;
    drive(9'h0C1, 32'hA1, 5'd1); tick();
    drive(9'h0C1, 32'hB2, 5'd2); tick();
    check("fl_full", in_ready, 0);
    drive(9'h0C1, 32'hC3, 5'd3); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl_no_C", out_valid, 0);

    // flush discards a same-cycle accepted input
    out_ready = 1'b0; in_valid = 1'b1;
    drive(9'h0C1, 32'hD4, 5'd4); tick();
    drive(9'h0C1, 32'hE5, 5'd5); out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_valid", out_valid, 0);
    tick();
    check("fl1_no_E", out_valid, 0);

    // mid-operation reset
    in_valid = 1'b1; out_ready = 1'b0;
    drive(9'h0F0, 32'h77, 5'd7); tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_rs_data", out_rs_data, 0);
    check("mrst_bubble", bubble_cnt, 0);

    // single-register variant: combinational ready
    in_valid0 = 1'b1; out_ready0 = 1'b0;
    drive(9'h033, 32'h55, 5'd9);
    tick();
    check("s0_valid", out_valid0, 1);
    check("s0_rs_data", out_rs_data0, 32'h55);
    drive(9'h034, 32'h66, 5'd10);
    #1;
    check("s0_ready_low", in_ready0, 0);
    out_ready0 = 1'b1;
    #1;
    check("s0_ready_comb", in_ready0, 1);
    tick();
    check("s0_replace", out_rs_data0, 32'h66);
    check("s0_replace_ctrl", out_ctrl0, 9'h034);
    in_valid0 = 1'b0;
    tick();
    check("s0_drain_valid", out_valid0, 0);
    check("s0_drain_ctrl", out_ctrl0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
